// File: rtl/inst_fetch.sv
// Instruction fetch and predecode stage.
// Holds the PC, issues one outstanding fetch at a time, and registers the
// returned word with its immediate-format code for the decode stage.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [2:0]  if_inst_type,
  output logic        if_illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_t;

  localparam logic [2:0] TYPE_U = 3'd0;
  localparam logic [2:0] TYPE_J = 3'd1;
  localparam logic [2:0] TYPE_I = 3'd2;
  localparam logic [2:0] TYPE_S = 3'd3;
  localparam logic [2:0] TYPE_B = 3'd4;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect_target;
  logic [2:0]  pre_type;
  logic        pre_illegal;
  logic [1:0]  unused_redirect_bits;

  // Redirect targets are always word aligned; the low bits are dropped.
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = redirect_pc[1:0];

  // A redirect in the same cycle suppresses the request so the address
  // never changes while a request is visible to memory.
  assign imem_req  = (state == S_REQ) && !redirect;
  assign imem_addr = pc;

  // Predecode the incoming word's opcode into its immediate format.
  always_comb begin
    pre_type    = TYPE_I;
    pre_illegal = 1'b0;
    case (imem_rdata[6:0])
      7'b0110111, 7'b0010111: pre_type = TYPE_U;
      7'b1101111:             pre_type = TYPE_J;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b0110011, 7'b0001111, 7'b1110011: pre_type = TYPE_I;
      7'b0100011:             pre_type = TYPE_S;
      7'b1100011:             pre_type = TYPE_B;
      default: begin
        pre_type    = TYPE_I;
        pre_illegal = 1'b1;
      end
    endcase
  end

  // Fetch sequencer: PC, state and the registered decode-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      if_valid     <= 1'b0;
      if_pc        <= 32'h0;
      if_inst      <= 32'h0;
      if_inst_type <= TYPE_I;
      if_illegal   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (redirect) begin
            pc <= redirect_target;
          end else if (imem_gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            // A response in the same cycle belongs to the old path.
            pc    <= redirect_target;
            state <= imem_rvalid ? S_REQ : S_DROP;
          end else if (imem_rvalid) begin
            if_inst      <= imem_rdata;
            if_pc        <= pc;
            if_valid     <= 1'b1;
            if_inst_type <= pre_type;
            if_illegal   <= pre_illegal;
            pc           <= pc + 32'd4;
            state        <= S_HOLD;
          end
        end
        S_DROP: begin
          // Still owed one stale response; swallow it before refetching.
          if (redirect) begin
            pc <= redirect_target;
          end
          if (imem_rvalid) begin
            state <= S_REQ;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            if_valid <= 1'b0;
            pc       <= redirect_target;
            state    <= S_REQ;
          end else if (!stall) begin
            if_valid <= 1'b0;
            state    <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized
// run checked against a transaction-level model of the fetch stream.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [2:0]  if_inst_type;
  logic        if_illegal;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_inst_type(if_inst_type),
    .if_illegal  (if_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcode table: RV32I opcodes and the immediate format each one uses.
  localparam logic [6:0] OPS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                                      7'h33, 7'h0F, 7'h73, 7'h23, 7'h63};
  localparam logic [2:0] TYS [11] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2,
                                      3'd2, 3'd2, 3'd2, 3'd3, 3'd4};

  int checks = 0;
  int failures = 0;

  // Memory model state
  logic [31:0] mem [64];
  bit          mbusy;
  int          mcnt;
  logic [31:0] maddr;
  int          gnt_pct = 100;
  int          rv_delay = 0;
  bit          last_gnt;
  bit          last_rvalid;
  logic [31:0] last_gnt_addr;
  logic [31:0] last_rdata;

  // Returns {illegal, type} by table lookup.
  function automatic logic [3:0] ref_decode(input logic [31:0] w);
    logic [3:0] r;
    r = {1'b1, 3'd2};
    for (int k = 0; k < 11; k++) begin
      if (w[6:0] == OPS[k]) r = {1'b0, TYS[k]};
    end
    return r;
  endfunction

  // One clock cycle: drive decode inputs, play memory, advance to just
  // after the next falling edge.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic stl);
    redirect    = redir;
    redirect_pc = tgt;
    stall       = stl;
    imem_rvalid = 1'b0;
    if (mbusy && mcnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem[maddr[7:2]];
      mbusy       = 1'b0;
    end else if (mbusy) begin
      mcnt--;
    end
    last_rvalid = imem_rvalid;
    last_rdata  = imem_rdata;
    #1;
    imem_gnt = 1'b0;
    last_gnt = 1'b0;
    if (imem_req && ($urandom_range(0, 99) < gnt_pct)) begin
      imem_gnt      = 1'b1;
      last_gnt      = 1'b1;
      last_gnt_addr = imem_addr;
      mbusy         = 1'b1;
      maddr         = imem_addr;
      mcnt          = (rv_delay < 0) ? int'($urandom_range(0, 2)) : rv_delay;
    end
    @(posedge clk);
    @(negedge clk);
    redirect    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    mbusy       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 20 && !if_valid; i++) step(1'b0, 32'h0, 1'b0);
    ok = if_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 0; redirect_pc = 0; stall = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; mbusy = 0;
    mem[0] = 32'h00500093;
    @(negedge clk); #1;
    checks++;
    if ({imem_req, if_valid, if_illegal} !== 3'b000 || if_pc !== 0 || if_inst !== 0 ||
        if_inst_type !== 3'd2 || imem_addr !== 0) begin
      failures++;
      $display("FAIL reset_values req=%b valid=%b ill=%b pc=%h inst=%h type=%0d addr=%h expected 0/0/0/0/0/2/0",
               imem_req, if_valid, if_illegal, if_pc, if_inst, if_inst_type, imem_addr);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL idle_no_req req=%b expected 0", imem_req);
    end
    step(0, 0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL first_req req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
    end
    step(0, 0, 0);
    checks++;
    if (if_valid !== 1'b0) begin
      failures++; $display("FAIL early_valid valid=%b expected 0", if_valid);
    end
    step(0, 0, 0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 0 || if_inst !== 32'h00500093 ||
        if_inst_type !== 3'd2 || if_illegal !== 1'b0) begin
      failures++;
      $display("FAIL first_fetch valid=%b pc=%h inst=%h type=%0d ill=%b expected 1/0/00500093/2/0",
               if_valid, if_pc, if_inst, if_inst_type, if_illegal);
    end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] words [4] = '{32'h12345037, 32'h008000EF, 32'h00112023, 32'h00208463};
    logic [2:0]  types [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
    logic [31:0] gq[$];
    logic [31:0] pq[$];
    logic [31:0] iq[$];
    logic [2:0]  tq[$];
    for (int k = 0; k < 4; k++) mem[k] = words[k];
    do_reset();
    for (int c = 0; c < 13; c++) begin
      step(0, 0, 0);
      if (last_gnt) gq.push_back(last_gnt_addr);
      if (if_valid) begin pq.push_back(if_pc); iq.push_back(if_inst); tq.push_back(if_inst_type); end
    end
    checks++;
    if (gq.size() != 4 || pq.size() != 4) begin
      failures++; $display("FAIL seq_counts gnts=%0d valids=%0d expected 4/4", gq.size(), pq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gq[k] !== 32'(4*k) || pq[k] !== 32'(4*k) || iq[k] !== words[k] || tq[k] !== types[k]) begin
          failures++;
          $display("FAIL seq_item%0d addr=%h pc=%h inst=%h type=%0d expected %h/%h/%h/%0d",
                   k, gq[k], pq[k], iq[k], tq[k], 4*k, 4*k, words[k], types[k]);
        end
      end
    end
    $display("test_sequential done");
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] hp, hi;
    logic [2:0]  ht;
    mem[0] = 32'h00A00113;
    do_reset();
    wait_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_timeout valid=0 expected 1"); end
    hp = if_pc; hi = if_inst; ht = if_inst_type;
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 1);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== hp || if_inst !== hi || if_inst_type !== ht || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold c=%0d valid=%b pc=%h inst=%h type=%0d req=%b expected 1/%h/%h/%0d/0",
                 c, if_valid, if_pc, if_inst, if_inst_type, imem_req, hp, hi, ht);
      end
    end
    step(0, 0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== hp + 32'd4 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release req=%b addr=%h valid=%b expected 1/%h/0", imem_req, imem_addr, if_valid, hp + 32'd4);
    end
    $display("test_stall done");
  endtask

  task automatic test_redirect_wait();
    bit seen;
    mem[0] = 32'hDEADBEEF;
    rv_delay = 2;
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    seen = 0;
    step(1, 32'h0000_0102, 0); seen |= if_valid;
    step(0, 0, 0);             seen |= if_valid;
    step(0, 0, 0);             seen |= if_valid;
    checks++;
    if (seen || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
      failures++;
      $display("FAIL redirect_wait valid_seen=%b req=%b addr=%h expected 0/1/00000100", seen, imem_req, imem_addr);
    end
    rv_delay = 0;
    $display("test_redirect_wait done");
  endtask

  task automatic test_redirect_hold();
    bit ok;
    mem[0] = 32'h00500093;
    do_reset();
    wait_valid(ok);
    step(1, 32'h0000_0203, 1);
    checks++;
    if (!ok || if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
      failures++;
      $display("FAIL redirect_hold reached=%b valid=%b req=%b addr=%h expected 1/0/1/00000200",
               ok, if_valid, imem_req, imem_addr);
    end
    $display("test_redirect_hold done");
  endtask

  task automatic test_wrap();
    bit ok;
    mem[63] = 32'h0000007F;
    do_reset();
    step(0, 0, 0);
    step(1, 32'hFFFF_FFFE, 0);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_target addr=%h expected fffffffc", imem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || if_pc !== 32'hFFFF_FFFC || if_inst !== 32'h7F || if_illegal !== 1'b1 || if_inst_type !== 3'd2) begin
      failures++;
      $display("FAIL wrap_fetch valid=%b pc=%h inst=%h ill=%b type=%0d expected 1/fffffffc/0000007f/1/2",
               ok, if_pc, if_inst, if_illegal, if_inst_type);
    end
    step(0, 0, 0);
    checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      failures++; $display("FAIL wrap_next addr=%h req=%b expected 00000000/1", imem_addr, imem_req);
    end
    step(0, 0, 0);
    rst_n = 1'b0;
    mbusy = 1'b0;
    #1;
    checks++;
    if ({imem_req, if_valid, if_illegal} !== 3'b000 || if_pc !== 0 || if_inst !== 0 ||
        if_inst_type !== 3'd2 || imem_addr !== 0) begin
      failures++;
      $display("FAIL midreset req=%b valid=%b ill=%b pc=%h inst=%h type=%0d addr=%h expected 0/0/0/0/0/2/0",
               imem_req, if_valid, if_illegal, if_pc, if_inst, if_inst_type, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("test_wrap done");
  endtask

  task automatic test_random();
    bit          exp_valid, infl_ok, redir, stl;
    logic [31:0] exp_addr, exp_pc, exp_inst, infl_addr, tgt, w;
    logic [3:0]  d;
    int          deliveries = 0;
    for (int k = 0; k < 64; k++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = OPS[$urandom_range(0, 10)];
      mem[k] = w;
    end
    gnt_pct = 60;
    rv_delay = -1;
    do_reset();
    step(0, 0, 0);
    exp_valid = 0; infl_ok = 0; exp_addr = 32'h0; exp_pc = 0; exp_inst = 0; infl_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (if_valid !== exp_valid) begin
        failures++; $display("FAIL rnd_valid cyc=%0d valid=%b expected %b", c, if_valid, exp_valid);
      end
      if (exp_valid) begin
        d = ref_decode(exp_inst);
        checks++;
        if (if_pc !== exp_pc || if_inst !== exp_inst || if_inst_type !== d[2:0] ||
            if_illegal !== d[3] || imem_req !== 1'b0) begin
          failures++;
          $display("FAIL rnd_data cyc=%0d pc=%h inst=%h type=%0d ill=%b req=%b expected %h/%h/%0d/%b/0",
                   c, if_pc, if_inst, if_inst_type, if_illegal, imem_req, exp_pc, exp_inst, d[2:0], d[3]);
        end
      end
      redir = ($urandom_range(0, 99) < 8);
      tgt   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      stl   = ($urandom_range(0, 99) < 40);
      step(redir, tgt, stl);
      if (exp_valid && (redir || !stl)) exp_valid = 0;
      if (redir) begin
        exp_addr = {tgt[31:2], 2'b00};
        infl_ok  = 0;
      end else begin
        if (last_rvalid && infl_ok) begin
          exp_valid = 1;
          exp_pc    = infl_addr;
          exp_inst  = last_rdata;
          exp_addr  = infl_addr + 32'd4;
          infl_ok   = 0;
          deliveries++;
        end
        if (last_gnt) begin
          checks++;
          if (last_gnt_addr !== exp_addr) begin
            failures++; $display("FAIL rnd_addr cyc=%0d addr=%h expected %h", c, last_gnt_addr, exp_addr);
          end
          infl_ok   = 1;
          infl_addr = exp_addr;
        end
      end
    end
    gnt_pct = 100;
    rv_delay = 0;
    $display("test_random done deliveries=%0d", deliveries);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch and predecode stage.
- Holds the PC and performs single-outstanding fetches from instruction memory.
- Registers the fetched word together with a 3-bit format code, then hands both to decode, which includes the immediate generator (inst / inst_type inputs).
- Supports a decode-side stall and a redirect from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; addr held stable while asserted.
- imem_addr  out  32  fetch address (= pc).
- imem_gnt  in  1  memory accepted request this cycle.
- imem_rvalid  in  1  read data valid (≥1 cycle after gnt).
- imem_rdata  in  32  instruction word.
- stall  in  1  decode cannot accept if_* this cycle.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0).
- if_valid  out  1  if_* outputs hold a valid instruction.
- if_pc  out  32  PC of if_inst.
- if_inst  out  32  fetched instruction.
- if_inst_type  out  3  format code: 0=U 1=J 2=I 3=S 4=B.
- if_illegal  out  1  opcode not RV32I.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, if_valid=0, if_pc=0, if_inst=0, if_inst_type=2, if_illegal=0.
- States: IDLE, REQ, WAIT, DROP, HOLD.
- imem_req = (state==REQ) && !redirect; imem_addr = pc at all times.
- IDLE: unconditionally → REQ on the next edge. First request occurs in cycle 2 after reset release.
- REQ:
  - redirect: pc←{redirect_pc[31:2],2'b00}, stay REQ. No request this cycle.
  - else gnt: → WAIT.
  - else: stay REQ, addr held.
- WAIT:
  - redirect && rvalid: data discarded, pc←redirect target, → REQ.
  - redirect && !rvalid: pc←target, → DROP.
  - rvalid: if_inst←rdata, if_pc←pc, if_valid←1, if_inst_type/if_illegal←predecode(rdata), pc←pc+4, → HOLD.
- DROP: waits for the stale response. On rvalid, discard and → REQ. A further redirect in DROP updates pc and stays in DROP.
- HOLD: if_* stable while if_valid=1.
  - redirect (priority over stall): if_valid←0, pc←target, → REQ.
  - else !stall: instruction consumed, if_valid←0, → REQ.
  - else: stay.
- if_valid is 1 only in HOLD.
- Latency: gnt and rvalid in consecutive cycles gives rdata visible on if_* 1 cycle after rvalid. Max throughput is 1 instruction per 3 cycles. Pipelining overlap is out of scope.
- PC arithmetic: 32-bit modulo, so 0xFFFF_FFFC+4 = 0x0000_0000.
- Predecode on opcode = inst[6:0]:
  - 0110111 LUI, 0010111 AUIPC → 0.
  - 1101111 JAL → 1.
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0110011 OP, 0001111 FENCE, 1110011 SYSTEM → 2.
  - 0100011 STORE → 3.
  - 1100011 BRANCH → 4.
  - Any other value (including inst[1:0]≠11) → type 2, if_illegal=1.
- A gnt or rvalid arriving in IDLE or HOLD is a protocol error and is ignored.
- rst_n asserted mid-transaction returns to the reset state immediately. The memory side must also be reset; a pending response is not tracked.

Test Plan:
- Reset release, RESET_PC=0, memory gnt same cycle, rvalid next cycle returning 0x00500093 → imem_addr=0, then if_valid=1, if_pc=0, if_inst=0x00500093, if_inst_type=2, if_illegal=0.
- Sequential fetch of 0x12345037 (LUI), 0x008000EF (JAL), 0x00112023 (SW), 0x00208463 (BEQ), with stall=0 → addrs 0,4,8,C; types 0,1,3,4; one if_valid pulse each.
- stall=1 for 5 cycles while in HOLD → if_* unchanged and imem_req=0 throughout. After stall drops, next imem_addr=pc+4.
- redirect to 0x0000_0102 during WAIT, rvalid 2 cycles later with 0xDEADBEEF → no if_valid for that word; next imem_addr=0x0000_0100.
- redirect in HOLD concurrent with stall=1 → if_valid falls next cycle, next request at the redirect target.
- Fetch at pc=0xFFFF_FFFC, then word 0x0000007F → if_illegal=1, if_inst_type=2; next imem_addr=0x0000_0000. Also assert rst_n low in WAIT → all outputs at reset values immediately.
